register_file: RTL and testbench

- 16 x 16-bit general-purpose register file for the byte_unit CPU.
- Consumes the write-back triple from the write-back stage (wb_regfile_writeback, wb_rd_id, wb_reg_write).
- Supplies two source operands to decode/execute.
- Includes a sequential debug-dump engine that streams all registers out on request via a valid/ready handshake, for the semaphore test harness.

---
 rtl/register_file.sv | 120 ++++++++++++
 tb/tb_register_file.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// register_file: 16 x 16-bit general-purpose registers for the byte_unit CPU.
// Two combinational read ports with write-first bypass from the write-back
// stage, plus a debug-dump engine that streams every register out over a
// valid/ready handshake.
//
// Dump engine states
//   state  | meaning
//   IDLE   | no dump in progress, waiting for dbg_dump_req
//   SEND   | presenting reg[dbg_idx], advancing on each accepted beat
//   DONE   | one-cycle gap after the last beat before returning to IDLE
module register_file #(
    parameter int DATA_W  = 16,
    parameter int NREGS   = 16,
    parameter int R0_ZERO = 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     suspend_cpu,
    input  logic                     wb_reg_write,
    input  logic [$clog2(NREGS)-1:0] wb_rd_id,
    input  logic [DATA_W-1:0]        wb_regfile_writeback,
    input  logic [$clog2(NREGS)-1:0] id_rs1_id,
    input  logic [$clog2(NREGS)-1:0] id_rs2_id,
    output logic [DATA_W-1:0]        rf_rs1_data,
    output logic [DATA_W-1:0]        rf_rs2_data,
    input  logic                     dbg_dump_req,
    output logic                     dbg_valid,
    input  logic                     dbg_ready,
    output logic [$clog2(NREGS)-1:0] dbg_idx,
    output logic [DATA_W-1:0]        dbg_data,
    output logic                     dbg_last,
    output logic                     dbg_busy
);

    localparam int ID_W = $clog2(NREGS);
    localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NREGS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [DATA_W-1:0] regs [NREGS];
    logic [1:0]        state;
    logic              wr_en;
    logic              r0_hit1;
    logic              r0_hit2;
    logic              r0_hitd;
    logic              byp1;
    logic              byp2;
    logic              bypd;

    // A write is architecturally visible only when not suspended and not
    // aimed at a hard-wired zero register.
    assign wr_en = wb_reg_write && !suspend_cpu &&
                   !((R0_ZERO != 0) && (wb_rd_id == '0));

    assign r0_hit1 = (R0_ZERO != 0) && (id_rs1_id == '0);
    assign r0_hit2 = (R0_ZERO != 0) && (id_rs2_id == '0);
    assign r0_hitd = (R0_ZERO != 0) && (dbg_idx == '0);

    assign byp1 = wr_en && (wb_rd_id == id_rs1_id);
    assign byp2 = wr_en && (wb_rd_id == id_rs2_id);
    assign bypd = wr_en && (wb_rd_id == dbg_idx);

    // Write-first reads: the value being written this cycle wins over storage.
    assign rf_rs1_data = r0_hit1 ? '0 : (byp1 ? wb_regfile_writeback : regs[id_rs1_id]);
    assign rf_rs2_data = r0_hit2 ? '0 : (byp2 ? wb_regfile_writeback : regs[id_rs2_id]);
    assign dbg_data    = r0_hitd ? '0 : (bypd ? wb_regfile_writeback : regs[dbg_idx]);

    assign dbg_valid = (state == S_SEND);
    assign dbg_last  = dbg_valid && (dbg_idx == LAST_IDX);
    assign dbg_busy  = (state != S_IDLE);

    // Register storage: clear all on reset, otherwise accept the write-back.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wb_rd_id] <= wb_regfile_writeback;
        end
    end

    // Dump engine: walks dbg_idx through every register, one accepted beat each.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= S_IDLE;
            dbg_idx <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    dbg_idx <= '0;
                    if (dbg_dump_req) begin
                        state <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (dbg_ready) begin
                        if (dbg_idx == LAST_IDX) begin
                            state   <= S_DONE;
                            dbg_idx <= '0;
                        end else begin
                            dbg_idx <= dbg_idx + ID_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    state   <= S_IDLE;
                    dbg_idx <= '0;
                end
                default: begin
                    state   <= S_IDLE;
                    dbg_idx <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: a table of read/write vectors followed by
// hand-written dump, backpressure, live-write and reset-abort sequences.
module tb_register_file;

    logic        clk = 1'b0;
    logic        rstn;
    logic        suspend_cpu;
    logic        wb_reg_write;
    logic [3:0]  wb_rd_id;
    logic [15:0] wb_regfile_writeback;
    logic [3:0]  id_rs1_id;
    logic [3:0]  id_rs2_id;
    logic [15:0] rf_rs1_data;
    logic [15:0] rf_rs2_data;
    logic        dbg_dump_req;
    logic        dbg_valid;
    logic        dbg_ready;
    logic [3:0]  dbg_idx;
    logic [15:0] dbg_data;
    logic        dbg_last;
    logic        dbg_busy;

    int checks   = 0;
    int failures = 0;

    register_file dut (
        .clk                  (clk),
        .rstn                 (rstn),
        .suspend_cpu          (suspend_cpu),
        .wb_reg_write         (wb_reg_write),
        .wb_rd_id             (wb_rd_id),
        .wb_regfile_writeback (wb_regfile_writeback),
        .id_rs1_id            (id_rs1_id),
        .id_rs2_id            (id_rs2_id),
        .rf_rs1_data          (rf_rs1_data),
        .rf_rs2_data          (rf_rs2_data),
        .dbg_dump_req         (dbg_dump_req),
        .dbg_valid            (dbg_valid),
        .dbg_ready            (dbg_ready),
        .dbg_idx              (dbg_idx),
        .dbg_data             (dbg_data),
        .dbg_last             (dbg_last),
        .dbg_busy             (dbg_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rstn;
        logic        sus;
        logic        we;
        logic [3:0]  rd;
        logic [15:0] wd;
        logic [3:0]  r1;
        logic [3:0]  r2;
        logic [15:0] e1;
        logic [15:0] e2;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] exp_data;
        int          accepted;
        int          cyc;
        logic        pat [4];

        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

        //            rstn  sus   we    rd     wd          r1     r2     e1          e2
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 4'd5, 16'h1234, 4'd5, 4'd5, 16'h1234, 16'h1234};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 4'd5, 4'd5, 16'h1234, 16'h1234};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 4'd5, 4'd5, 16'h0000, 16'h0000};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 4'd3, 16'hBEEF, 4'd3, 4'd3, 16'hBEEF, 16'hBEEF};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 4'd3, 4'd3, 16'hBEEF, 16'hBEEF};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 4'd0, 16'hFFFF, 4'd0, 4'd3, 16'h0000, 16'hBEEF};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 4'd0, 4'd0, 16'h0000, 16'h0000};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 4'd7, 16'h0055, 4'd7, 4'd7, 16'h0055, 16'h0055};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 4'd7, 16'h00AA, 4'd7, 4'd3, 16'h0055, 16'hBEEF};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 4'd7, 4'd7, 16'h0055, 16'h0055};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 4'd9, 16'h1357, 4'd9, 4'd3, 16'h1357, 16'hBEEF};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 4'd9, 4'd5, 16'h1357, 16'h0000};

        rstn = 1'b0; suspend_cpu = 1'b0; wb_reg_write = 1'b0; wb_rd_id = 4'd0;
        wb_regfile_writeback = 16'h0; id_rs1_id = 4'd0; id_rs2_id = 4'd0;
        dbg_dump_req = 1'b0; dbg_ready = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        chk("reset_busy", 32'(dbg_busy), 32'd0);
        chk("reset_valid", 32'(dbg_valid), 32'd0);
        chk("reset_idx", 32'(dbg_idx), 32'd0);

        // Table-driven read/write vectors, compared before each edge.
        for (int v = 0; v < 12; v++) begin
            rstn = vecs[v].rstn; suspend_cpu = vecs[v].sus; wb_reg_write = vecs[v].we;
            wb_rd_id = vecs[v].rd; wb_regfile_writeback = vecs[v].wd;
            id_rs1_id = vecs[v].r1; id_rs2_id = vecs[v].r2;
            #1;
            chk($sformatf("vec%0d_rs1", v), 32'(rf_rs1_data), 32'(vecs[v].e1));
            chk($sformatf("vec%0d_rs2", v), 32'(rf_rs2_data), 32'(vecs[v].e2));
            if (v == 2) begin
                chk("post_reset_busy", 32'(dbg_busy), 32'd0);
                chk("post_reset_valid", 32'(dbg_valid), 32'd0);
            end
            tick();
        end
        rstn = 1'b1; suspend_cpu = 1'b0; wb_reg_write = 1'b0;

        // Load reg[i] = 0x0100 + i.
        for (int i = 1; i < 16; i++) begin
            wb_reg_write = 1'b1; wb_rd_id = 4'(i); wb_regfile_writeback = 16'h0100 + 16'(i);
            tick();
        end
        wb_reg_write = 1'b0;

        // Full dump with ready held high.
        dbg_ready = 1'b1;
        dbg_dump_req = 1'b1;
        tick();
        dbg_dump_req = 1'b0;
        for (int b = 0; b < 16; b++) begin
            exp_data = (b == 0) ? 16'h0000 : 16'h0100 + 16'(b);
            chk($sformatf("dump_valid_%0d", b), 32'(dbg_valid), 32'd1);
            chk($sformatf("dump_idx_%0d", b), 32'(dbg_idx), 32'(b));
            chk($sformatf("dump_data_%0d", b), 32'(dbg_data), 32'(exp_data));
            chk($sformatf("dump_last_%0d", b), 32'(dbg_last), (b == 15) ? 32'd1 : 32'd0);
            tick();
        end
        chk("done_valid", 32'(dbg_valid), 32'd0);
        chk("done_busy", 32'(dbg_busy), 32'd1);
        chk("done_last", 32'(dbg_last), 32'd0);
        tick();
        chk("idle_busy", 32'(dbg_busy), 32'd0);

        // Backpressure: ready pattern 1,0,0,1; every valid cycle must show
        // the next not-yet-accepted index.
        dbg_dump_req = 1'b1;
        tick();
        dbg_dump_req = 1'b0;
        accepted = 0;
        cyc = 0;
        while (accepted < 16 && cyc < 200) begin
            dbg_ready = pat[cyc % 4];
            #1;
            if (dbg_valid) begin
                if (dbg_idx != 4'(accepted)) begin
                    chk("bp_idx", 32'(dbg_idx), 32'(accepted));
                end
                if (dbg_ready) begin
                    exp_data = (accepted == 0) ? 16'h0000 : 16'h0100 + 16'(accepted);
                    chk($sformatf("bp_data_%0d", accepted), 32'(dbg_data), 32'(exp_data));
                    accepted++;
                end
            end
            cyc++;
            tick();
        end
        chk("bp_accepted", 32'(accepted), 32'd16);
        dbg_ready = 1'b0;
        chk("bp_done_valid", 32'(dbg_valid), 32'd0);
        tick();
        chk("bp_idle_busy", 32'(dbg_busy), 32'd0);

        // Live write into the index currently presented while stalled.
        dbg_dump_req = 1'b1;
        tick();
        dbg_dump_req = 1'b0;
        dbg_ready = 1'b1;
        tick();
        dbg_ready = 1'b0;
        chk("live_idx", 32'(dbg_idx), 32'd1);
        chk("live_data_before", 32'(dbg_data), 32'h0101);
        wb_reg_write = 1'b1; wb_rd_id = 4'd1; wb_regfile_writeback = 16'hA5A5;
        #1;
        chk("live_data_bypass", 32'(dbg_data), 32'hA5A5);
        tick();
        wb_reg_write = 1'b0;
        #1;
        chk("live_data_after", 32'(dbg_data), 32'hA5A5);
        chk("live_idx_hold", 32'(dbg_idx), 32'd1);

        // Continue to beat 6 accepted, then reset mid-dump.
        dbg_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
        end
        chk("abort_pre_idx", 32'(dbg_idx), 32'd7);
        chk("abort_pre_valid", 32'(dbg_valid), 32'd1);
        rstn = 1'b0;
        dbg_ready = 1'b0;
        tick();
        rstn = 1'b1;
        chk("abort_valid", 32'(dbg_valid), 32'd0);
        chk("abort_idx", 32'(dbg_idx), 32'd0);
        chk("abort_busy", 32'(dbg_busy), 32'd0);
        dbg_ready = 1'b1;
        tick();
        tick();
        chk("abort_no_beats", 32'(dbg_valid), 32'd0);
        dbg_dump_req = 1'b1;
        tick();
        dbg_dump_req = 1'b0;
        chk("restart_valid", 32'(dbg_valid), 32'd1);
        chk("restart_idx", 32'(dbg_idx), 32'd0);
        tick();
        chk("restart_idx1", 32'(dbg_idx), 32'd1);
        chk("restart_data1", 32'(dbg_data), 32'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
